// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes a raw, bouncy level input into the clk
// domain and accepts a level change only after DEBOUNCE_CYCLES consecutive
// synchronized samples at the new level. Rejected candidate transitions are
// tallied in a saturating 8-bit glitch counter for debug.
module switch_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       clr_glitch,
    output logic       dout,
    output logic       busy,
    output logic [7:0] glitch_count
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_t;

    // Last count value before a candidate is accepted; the counter never
    // advances past it, so it cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_in_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   glitch_s;
    logic                   dout_r;
    logic                   busy_r;
    logic [7:0]             glitch_r;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    // Only the first flop of this chain ever samples the asynchronous din.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_in_s = sync_r[SYNC_STAGES-1];

    // Next-state logic: qualify a candidate level, or drop it as a glitch.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        glitch_s    = 1'b0;
        case (state_r)
            ST_LOW: begin
                if (sync_in_s) begin
                    // This sample is the first of the qualifying run.
                    state_nxt_s = ST_CHK_HIGH;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_CHK_HIGH: begin
                if (!sync_in_s) begin
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                    glitch_s    = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_CHK_HIGH;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_in_s) begin
                    state_nxt_s = ST_CHK_LOW;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_CHK_LOW: begin
                if (sync_in_s) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = CNT_ZERO;
                    glitch_s    = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_CHK_LOW;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_LOW;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and stability counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_LOW;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Outputs are decoded from the next state and registered, so they track
    // the state register exactly and have no path from din.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            dout_r <= (state_nxt_s == ST_HIGH) || (state_nxt_s == ST_CHK_LOW);
            busy_r <= (state_nxt_s == ST_CHK_HIGH) || (state_nxt_s == ST_CHK_LOW);
        end
    end

    // Glitch tally: clear wins over a coincident rejection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            glitch_r <= 8'd0;
        end else if (clr_glitch) begin
            glitch_r <= 8'd0;
        end else if (glitch_s) begin
            glitch_r <= sat_inc8(glitch_r);
        end else begin
            glitch_r <= glitch_r;
        end
    end

    assign dout         = dout_r;
    assign busy         = busy_r;
    assign glitch_count = glitch_r;

endmodule
